// File: rtl/mem_loader.sv
// mem_loader: boot-time loader that streams a little-endian image into memory.
//
// Byte stream format: 4-byte word count N, then N 4-byte data words, all
// little-endian. Each data word is written to BASE_ADDR + 4*k with a single
// cycle full-word write. busy holds the core in reset until the image is in.
//
// Optional feature (macro MEM_LOADER_CHECKSUM_EN): a modulo-2^32 running sum
// of written words is compared against a 4-byte trailer. A match goes to DONE
// and a mismatch goes to ERROR. Without the macro there is no trailer.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_data      byte stream input (handshake with in_ready)
//   in_ready              loader accepts a byte this cycle
//   memory__address       byte address of the write
//   memory__write_data    write word
//   memory__write_enable  byte-lane enables (4'hF during a write, else 0)
//   busy                  load in progress (core held in reset)
//   done / error          sticky terminal status
//   words_written         words committed so far

// One stored byte lane of the word assembler.
module mem_loader_lane #(
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LANE_W-1:0] d,
  output logic [LANE_W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 512,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [31:0]      memory__address,
  output logic [31:0]      memory__write_data,
  output logic [3:0]       memory__write_enable,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

`ifdef MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HEADER, S_COLLECT, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HEADER, S_COLLECT, S_WRITE, S_DONE, S_ERROR
  } state_t;
`endif

  state_t state_q, state_d;

  logic [1:0]                          byte_idx;
  logic [NUM_LANES-2:0][LANE_W-1:0]    lane_q;
  logic [31:0]                         word_in;
  logic [31:0]                         hdr_n;
  logic [31:0]                         addr_q;
  logic [31:0]                         data_q;
  logic [CNT_W-1:0]                    ww_q;
  logic                                xfer;
  logic                                byte4;
  logic                                last_word;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0]                         sum_q;
`endif

  // The top byte is never stored: the 4th byte completes the word on the
  // handshake edge straight from in_data.
  genvar g;
  generate
    for (g = 0; g < NUM_LANES - 1; g++) begin : g_lane
      mem_loader_lane #(.LANE_W(LANE_W)) u_lane (
        .clk   (clk),
        .reset (reset),
        .load  (xfer && (byte_idx == 2'(g))),
        .d     (in_data),
        .q     (lane_q[g])
      );
    end
  endgenerate

  assign word_in   = {in_data, lane_q[2], lane_q[1], lane_q[0]};
  assign xfer      = in_valid && in_ready;
  // Used only in states where in_ready=1; kept free of in_ready so the
  // next-state logic does not loop through its own output.
  assign byte4     = in_valid && (byte_idx == 2'd3);
  assign last_word = (32'(ww_q) + 32'd1) == hdr_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_HEADER;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d              = state_q;
    in_ready             = 1'b0;
    busy                 = 1'b1;
    done                 = 1'b0;
    error                = 1'b0;
    memory__write_enable = 4'h0;
    case (state_q)
      S_HEADER: begin
        in_ready = 1'b1;
        if (byte4) begin
          if (word_in == 32'd0)
`ifdef MEM_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          else if (word_in > 32'(MAX_WORDS)) state_d = S_ERROR;
          else                               state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        in_ready = 1'b1;
        if (byte4) state_d = S_WRITE;
      end
      S_WRITE: begin
        memory__write_enable = 4'hF;
        if (last_word)
`ifdef MEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        else
          state_d = S_COLLECT;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        if (byte4) state_d = (word_in == sum_q) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: state_d = S_HEADER;
    endcase
  end

  // Datapath: address/data are latched on the completing byte so the write
  // cycle presents them from flops; they hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= 2'd0;
      hdr_n    <= 32'd0;
      addr_q   <= BASE_ADDR;
      data_q   <= 32'd0;
      ww_q     <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q    <= 32'd0;
`endif
    end else begin
      if (xfer) byte_idx <= byte_idx + 2'd1;
      if (xfer && byte_idx == 2'd3 && state_q == S_HEADER) hdr_n <= word_in;
      if (xfer && byte_idx == 2'd3 && state_q == S_COLLECT) begin
        addr_q <= BASE_ADDR + (32'(ww_q) << 2);
        data_q <= word_in;
      end
      if (state_q == S_WRITE) begin
        ww_q  <= ww_q + 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_q <= sum_q + data_q;
`endif
      end
    end
  end

  assign memory__address    = addr_q;
  assign memory__write_data = data_q;
  assign words_written      = ww_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: stimulus pushes expected writes, a
// negedge monitor pops and compares every write the DUT issues.
module tb_mem_loader;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] maddr, mdata;
  logic [3:0]  mwe;
  logic        busy, done, error;
  logic [15:0] words_written;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(512), .CNT_W(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_data              (in_data),
    .in_ready             (in_ready),
    .memory__address      (maddr),
    .memory__write_data   (mdata),
    .memory__write_enable (mwe),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .words_written        (words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every asserted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && mwe !== 4'h0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %h data %h we %h", maddr, mdata, mwe);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", maddr, e.addr);
        check("wr_data", mdata, e.data);
        check("wr_en", 32'(mwe), 32'hF);
        check("ready_in_write", 32'(in_ready), 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"},     32'(busy), 32'd1);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_error"},    32'(error), 32'd0);
    check({tag, "_ww"},       32'(words_written), 32'd0);
    check({tag, "_addr"},     maddr, BASE);
    check({tag, "_data"},     mdata, 32'd0);
    check({tag, "_we"},       32'(mwe), 32'd0);
  endtask

  // Two-word image; trailer is the sum 0x12345678+0xDEADBEEF when enabled.
  task automatic two_word_load(input int gap, input logic [31:0] trailer);
    exp_q.push_back('{addr: BASE,         data: 32'h1234_5678});
    exp_q.push_back('{addr: BASE + 32'd4, data: 32'hDEAD_BEEF});
    send_word(32'd2, gap);
    send_word(32'h1234_5678, gap);
    send_word(32'hDEAD_BEEF, gap);
`ifdef MEM_LOADER_CHECKSUM_EN
    send_word(trailer, gap);
`else
    if (trailer != 32'd0) ;
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    check_reset_vals("por");
    do_reset();
    check_reset_vals("rst");

    // Two-word load, back-to-back bytes.
    two_word_load(0, 32'hF0E2_1567);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_error", 32'(error), 32'd0);
    check("t1_ww", 32'(words_written), 32'd2);
    check("t1_ready", 32'(in_ready), 32'd0);
    check("t1_pending", exp_q.size(), 32'd0);

    // Zero-length header.
    do_reset();
    send_word(32'd0, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    check("t2_check_busy", 32'(busy), 32'd1);
    check("t2_check_ready", 32'(in_ready), 32'd1);
    send_word(32'd0, 0);
`endif
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t2_ww", 32'(words_written), 32'd0);
    check("t2_pending", exp_q.size(), 32'd0);

    // Oversized header: N = 0x201.
    do_reset();
    send_word(32'h0000_0201, 0);
    check("t3_error", 32'(error), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_ready", 32'(in_ready), 32'd0);
    check("t3_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t3_error_sticky", 32'(error), 32'd1);
    check("t3_ww", 32'(words_written), 32'd0);

    // Same image with 3-cycle gaps between every byte.
    do_reset();
    two_word_load(3, 32'hF0E2_1567);
    check("t4_done", 32'(done), 32'd1);
    check("t4_ww", 32'(words_written), 32'd2);
    check("t4_pending", exp_q.size(), 32'd0);

    // Reset after 6 data bytes of a 2-word load.
    do_reset();
    exp_q.push_back('{addr: BASE, data: 32'h1234_5678});
    send_word(32'd2, 0);
    send_word(32'h1234_5678, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_pending_pre", exp_q.size(), 32'd0);
    exp_q.push_back('{addr: BASE, data: 32'h1122_3344});
    send_word(32'd1, 0);
    send_word(32'h1122_3344, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    send_word(32'h1122_3344, 0);
`endif
    repeat (2) @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
    check("t5_ww", 32'(words_written), 32'd1);
    check("t5_pending", exp_q.size(), 32'd0);

`ifdef MEM_LOADER_CHECKSUM_EN
    // Bad trailer after both writes.
    do_reset();
    two_word_load(0, 32'd0);
    check("t6_error", 32'(error), 32'd1);
    check("t6_done", 32'(done), 32'd0);
    check("t6_ww", 32'(words_written), 32'd2);
    check("t6_pending", exp_q.size(), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
